// File: rtl/rgb_mixer_pkg.sv
// Shared types and palette for the RGB mixer: fade-sequencer state encoding
// and the four-colour auto-mode palette.
package rgb_mixer_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    FADE   = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Each palette entry is a per-channel full/off mask; the top level expands a
  // set bit to an all-ones level of whatever WIDTH it is built with.
  function automatic logic [2:0] palette_mask(input logic [1:0] idx);
    logic [2:0] m;
    case (idx)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One colour channel: holds the level register and moves it one step toward
// its target when asked, or loads a pass-through value.
module fade_channel
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] level,
  output logic             at_next_target
);

  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;

  // Moving only toward an in-range target keeps the level in range without clamping.
  always_comb begin
    level_d = level_q;
    if (level_q < target)      level_d = level_q + WIDTH'(1);
    else if (level_q > target) level_d = level_q - WIDTH'(1);
  end

  assign at_next_target = (level_d == target);
  assign level          = level_q;

  always_ff @(posedge clk) begin
    if (reset)     level_q <= '0;
    else if (load) level_q <= load_val;
    else if (step) level_q <= level_d;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Chooses the PWM levels for the three RGB channels: manual pass-through of the
// encoder values, or an automatic fade/hold walk around the colour palette.
module rgb_fade_sequencer
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 1024,
  parameter int HOLD_STEPS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_toggle,
  input  logic [WIDTH-1:0] manual0,
  input  logic [WIDTH-1:0] manual1,
  input  logic [WIDTH-1:0] manual2,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic             auto_mode,
  output logic             busy,
  output logic [1:0]       color_idx
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_STEPS + 1);

  state_e        state_q;
  logic          toggle_q;
  logic [PW-1:0] presc_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [1:0]    color_q;
  logic          auto_q;
  logic          busy_q;

  logic          edge_w;
  logic          tick_w;
  logic          load_w;
  logic          step_w;
  logic [2:0]    mask_w;
  logic [2:0]    at_w;

  assign edge_w = mode_toggle & ~toggle_q;
  assign tick_w = (presc_q == PW'(TICK_DIV - 1));
  assign hold_d = hold_q + HW'(1);
  assign mask_w = palette_mask(color_q);

  // An edge wins over a coincident tick, so no load or step happens on that cycle.
  assign load_w = (state_q == MANUAL) & ~edge_w;
  assign step_w = (state_q == FADE) & tick_w & ~edge_w;

  fade_channel #(.WIDTH(WIDTH)) u_ch0 (
    .clk(clk), .reset(reset), .load(load_w), .load_val(manual0), .step(step_w),
    .target({WIDTH{mask_w[0]}}), .level(level0), .at_next_target(at_w[0])
  );
  fade_channel #(.WIDTH(WIDTH)) u_ch1 (
    .clk(clk), .reset(reset), .load(load_w), .load_val(manual1), .step(step_w),
    .target({WIDTH{mask_w[1]}}), .level(level1), .at_next_target(at_w[1])
  );
  fade_channel #(.WIDTH(WIDTH)) u_ch2 (
    .clk(clk), .reset(reset), .load(load_w), .load_val(manual2), .step(step_w),
    .target({WIDTH{mask_w[2]}}), .level(level2), .at_next_target(at_w[2])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MANUAL;
      toggle_q <= 1'b1;
      presc_q  <= '0;
      hold_q   <= '0;
      color_q  <= 2'd0;
      auto_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      toggle_q <= mode_toggle;
      presc_q  <= tick_w ? '0 : presc_q + PW'(1);
      case (state_q)
        MANUAL: begin
          if (edge_w) begin
            state_q <= FADE;
            presc_q <= '0;
            auto_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FADE: begin
          if (edge_w) begin
            state_q <= MANUAL;
            auto_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick_w && (&at_w)) begin
            state_q <= HOLD;
            hold_q  <= '0;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (edge_w) begin
            state_q <= MANUAL;
            auto_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick_w) begin
            hold_q <= hold_d;
            if (hold_d == HW'(HOLD_STEPS)) begin
              color_q <= color_q + 2'd1;
              state_q <= FADE;
              busy_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= MANUAL;
          auto_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign auto_mode = auto_q;
  assign busy      = busy_q;
  assign color_idx = color_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with TICK_DIV=4, HOLD_STEPS=2.
module tb_rgb_fade_sequencer;

  localparam int W  = 8;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode_toggle;
  logic [W-1:0] manual0, manual1, manual2;
  logic [W-1:0] level0, level1, level2;
  logic         auto_mode, busy;
  logic [1:0]   color_idx;

  int errors = 0;
  int checks = 0;

  rgb_fade_sequencer #(.WIDTH(W), .TICK_DIV(TD), .HOLD_STEPS(2)) dut (
    .clk(clk), .reset(reset), .mode_toggle(mode_toggle),
    .manual0(manual0), .manual1(manual1), .manual2(manual2),
    .level0(level0), .level1(level1), .level2(level2),
    .auto_mode(auto_mode), .busy(busy), .color_idx(color_idx)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    cycles(n * TD);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lv(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2);
    chk(tag, {8'h00, level0, level1, level2}, {8'h00, e0, e1, e2});
  endtask

  task automatic chk_st(input string tag, input logic a, input logic b, input logic [1:0] c);
    chk(tag, {29'd0, auto_mode, busy, color_idx}, {29'd0, a, b, c});
  endtask

  initial begin
    reset = 1'b1; mode_toggle = 1'b0;
    manual0 = 8'd0; manual1 = 8'd0; manual2 = 8'd0;
    cycles(2);
    chk_lv("reset_levels", 8'd0, 8'd0, 8'd0);
    chk_st("reset_status", 1'b0, 1'b0, 2'd0);
    reset = 1'b0;

    // Manual pass-through
    manual0 = 8'd10; manual1 = 8'd20; manual2 = 8'd30;
    cycles(1);
    chk_lv("passthru", 8'd10, 8'd20, 8'd30);

    // Fade toward palette 0 (255,0,0)
    manual0 = 8'd250; manual1 = 8'd0; manual2 = 8'd5;
    cycles(1);
    chk_lv("passthru2", 8'd250, 8'd0, 8'd5);
    mode_toggle = 1'b1;
    cycles(1);
    mode_toggle = 1'b0;
    chk_st("fade_entry", 1'b1, 1'b1, 2'd0);
    chk_lv("fade_entry_lv", 8'd250, 8'd0, 8'd5);
    ticks(1);
    chk_lv("fade_tick1", 8'd251, 8'd0, 8'd4);
    ticks(3);
    chk_lv("fade_tick4", 8'd254, 8'd0, 8'd1);
    chk_st("fade_tick4_st", 1'b1, 1'b1, 2'd0);
    ticks(1);
    chk_lv("fade_tick5", 8'd255, 8'd0, 8'd0);
    chk_st("hold0", 1'b1, 1'b0, 2'd0);

    // Hold, advance to idx1 and fade to (0,255,0)
    ticks(1);
    chk_st("hold0_t1", 1'b1, 1'b0, 2'd0);
    ticks(1);
    chk_st("advance1", 1'b1, 1'b1, 2'd1);
    chk_lv("advance1_lv", 8'd255, 8'd0, 8'd0);
    ticks(1);
    chk_lv("fade1_t1", 8'd254, 8'd1, 8'd0);
    ticks(253);
    chk_lv("fade1_t254", 8'd1, 8'd254, 8'd0);
    chk_st("fade1_t254_st", 1'b1, 1'b1, 2'd1);
    ticks(1);
    chk_lv("fade1_t255", 8'd0, 8'd255, 8'd0);
    chk_st("hold1", 1'b1, 1'b0, 2'd1);

    // idx2 (0,0,255), then idx3 (255,255,255)
    ticks(2);
    chk_st("advance2", 1'b1, 1'b1, 2'd2);
    ticks(255);
    chk_lv("fade2_done", 8'd0, 8'd0, 8'd255);
    chk_st("hold2", 1'b1, 1'b0, 2'd2);
    ticks(2);
    chk_st("advance3", 1'b1, 1'b1, 2'd3);
    ticks(255);
    chk_lv("fade3_done", 8'd255, 8'd255, 8'd255);
    chk_st("hold3", 1'b1, 1'b0, 2'd3);

    // Palette wrap back to idx0
    ticks(2);
    chk_st("wrap0", 1'b1, 1'b1, 2'd0);
    ticks(1);
    chk_lv("wrap0_t1", 8'd255, 8'd254, 8'd254);

    // Edge coincident with tick in FADE
    cycles(TD - 1);
    manual0 = 8'd7; manual1 = 8'd8; manual2 = 8'd9;
    mode_toggle = 1'b1;
    cycles(1);
    mode_toggle = 1'b0;
    chk_lv("edge_tick_nostep", 8'd255, 8'd254, 8'd254);
    chk_st("edge_tick_manual", 1'b0, 1'b0, 2'd0);
    cycles(1);
    chk_lv("edge_tick_follow", 8'd7, 8'd8, 8'd9);
    manual0 = 8'd100; manual1 = 8'd101; manual2 = 8'd102;
    cycles(1);
    chk_lv("manual_latency", 8'd100, 8'd101, 8'd102);

    // Reset mid-FADE with mode_toggle held high
    mode_toggle = 1'b1;
    cycles(1);
    chk_st("refade_entry", 1'b1, 1'b1, 2'd0);
    ticks(1);
    chk_lv("refade_t1", 8'd101, 8'd100, 8'd101);
    reset = 1'b1;
    cycles(1);
    chk_lv("midreset_lv", 8'd0, 8'd0, 8'd0);
    chk_st("midreset_st", 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    cycles(3);
    chk_st("held_high_no_edge", 1'b0, 1'b0, 2'd0);
    chk_lv("held_high_passthru", 8'd100, 8'd101, 8'd102);
    mode_toggle = 1'b0;
    cycles(1);
    mode_toggle = 1'b1;
    cycles(1);
    chk_st("new_edge_fade", 1'b1, 1'b1, 2'd0);
    chk_lv("new_edge_fade_lv", 8'd100, 8'd101, 8'd102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
